// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Parametrised VGA raster timing generator. It produces the horizontal and
//   vertical beam coordinates, sync pulses, a visible-area flag, line/frame
//   start strobes, a vertical-blank flag and a free-running frame counter.
//   The counters advance only on clock edges where pix_en is high.
//
// Optional build macro:
//   VGA_TIMING_SYNC_DELAY_EN - when defined, hsync, vsync and display_on are
//   each delayed by a SYNC_DELAY-deep shift register clocked on every clk
//   (independent of pix_en). This lines sync up with a pattern pipeline of
//   the same latency. Coordinates, strobes, in_vblank and frame_count stay
//   undelayed. When undefined, SYNC_DELAY has no effect on the outputs.
//
// Ports:
//   clk          in   pixel/system clock
//   reset        in   asynchronous, active-high reset
//   pix_en       in   clock enable for the beam counters
//   hpos         out  horizontal position, 0..H_TOTAL-1
//   vpos         out  vertical position, 0..V_TOTAL-1
//   hsync        out  horizontal sync, level HSYNC_ACTIVE during the pulse
//   vsync        out  vertical sync, level VSYNC_ACTIVE during the pulse
//   display_on   out  high inside the visible area
//   line_start   out  high while hpos==0 and pix_en=1
//   frame_start  out  high while hpos==0, vpos==0 and pix_en=1
//   in_vblank    out  high when vpos>=V_DISPLAY
//   frame_count  out  completed-frame counter, wraps modulo 2^FC_W
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned H_DISPLAY    = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BACK       = 48,
  parameter int unsigned V_DISPLAY    = 480,
  parameter int unsigned V_BOTTOM     = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_TOP        = 33,
  parameter bit          HSYNC_ACTIVE = 1'b1,
  parameter bit          VSYNC_ACTIVE = 1'b1,
  parameter int unsigned CW           = 10,
  parameter int unsigned FC_W         = 12,
  parameter int unsigned FRAME_INIT   = 0,
  parameter int unsigned SYNC_DELAY   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pix_en,
  output logic [CW-1:0]   hpos,
  output logic [CW-1:0]   vpos,
  output logic            hsync,
  output logic            vsync,
  output logic            display_on,
  output logic            line_start,
  output logic            frame_start,
  output logic            in_vblank,
  output logic [FC_W-1:0] frame_count
);

  // -------------------------------------------------------------------------
  // Derived timing constants
  // -------------------------------------------------------------------------
  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
  localparam int unsigned H_SS_I  = H_DISPLAY + H_FRONT;
  localparam int unsigned H_SE_I  = H_SS_I + H_SYNC - 1;
  localparam int unsigned V_SS_I  = V_DISPLAY + V_BOTTOM;
  localparam int unsigned V_SE_I  = V_SS_I + V_SYNC - 1;

  // All compares happen at CW bits, unsigned.
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SS   = CW'(H_SS_I);
  localparam logic [CW-1:0] H_SE   = CW'(H_SE_I);
  localparam logic [CW-1:0] V_SS   = CW'(V_SS_I);
  localparam logic [CW-1:0] V_SE   = CW'(V_SE_I);
  localparam logic [CW-1:0] H_VIS  = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_VIS  = CW'(V_DISPLAY);

  localparam logic [FC_W-1:0] FC_RESET = FC_W'(FRAME_INIT);

  // -------------------------------------------------------------------------
  // Parameter legality checks (simulation-time)
  // -------------------------------------------------------------------------
  if ((H_TOTAL > (1 << CW)) || (V_TOTAL > (1 << CW))) begin : g_bad_cw
    always @(posedge clk) begin
      $error("vga_timing_gen: CW=%0d too narrow for H_TOTAL=%0d / V_TOTAL=%0d",
             CW, H_TOTAL, V_TOTAL);
    end
  end

  if ((SYNC_DELAY < 1) || (SYNC_DELAY > 8)) begin : g_bad_delay
    always @(posedge clk) begin
      $error("vga_timing_gen: SYNC_DELAY=%0d outside 1..8", SYNC_DELAY);
    end
  end

  // -------------------------------------------------------------------------
  // Beam counters and frame counter
  // -------------------------------------------------------------------------
  logic [CW-1:0]   r_hpos;
  logic [CW-1:0]   r_vpos;
  logic [FC_W-1:0] r_frame;
  logic            r_hsync;
  logic            r_vsync;

  logic [CW-1:0]   w_hpos_d;
  logic [CW-1:0]   w_vpos_d;
  logic [FC_W-1:0] w_frame_d;
  logic            w_hsync_d;
  logic            w_vsync_d;

  always_comb begin
    w_hpos_d  = r_hpos;
    w_vpos_d  = r_vpos;
    w_frame_d = r_frame;
    if (pix_en) begin
      if (r_hpos == H_LAST) begin
        w_hpos_d = '0;
        if (r_vpos == V_LAST) begin
          // Line wrap and frame wrap share this edge.
          w_vpos_d  = '0;
          w_frame_d = r_frame + 1'b1;
        end else begin
          w_vpos_d = r_vpos + 1'b1;
        end
      end else begin
        w_hpos_d = r_hpos + 1'b1;
      end
    end
  end

  // Syncs decode the next-state counters so that, once registered, they line
  // up with hpos/vpos instead of trailing them by a clock.
  always_comb begin
    w_hsync_d = ((w_hpos_d >= H_SS) && (w_hpos_d <= H_SE)) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
    w_vsync_d = ((w_vpos_d >= V_SS) && (w_vpos_d <= V_SE)) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hpos  <= '0;
      r_vpos  <= '0;
      r_frame <= FC_RESET;
      r_hsync <= ~HSYNC_ACTIVE;
      r_vsync <= ~VSYNC_ACTIVE;
    end else begin
      r_hpos  <= w_hpos_d;
      r_vpos  <= w_vpos_d;
      r_frame <= w_frame_d;
      r_hsync <= w_hsync_d;
      r_vsync <= w_vsync_d;
    end
  end

  // -------------------------------------------------------------------------
  // Combinational decode from the counter registers
  // -------------------------------------------------------------------------
  logic w_display_on;
  logic w_at_h0;
  logic w_at_v0;

  always_comb begin
    w_at_h0      = (r_hpos == '0);
    w_at_v0      = (r_vpos == '0);
    w_display_on = (r_hpos < H_VIS) && (r_vpos < V_VIS);
  end

  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign frame_count = r_frame;
  assign in_vblank   = (r_vpos >= V_VIS);
  // Strobes are gated by pix_en so a held pixel never repeats a strobe.
  assign line_start  = w_at_h0 & pix_en;
  assign frame_start = w_at_h0 & w_at_v0 & pix_en;

  // -------------------------------------------------------------------------
  // Sync / display_on output stage
  // -------------------------------------------------------------------------
`ifdef VGA_TIMING_SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] r_hs_pipe;
  logic [SYNC_DELAY-1:0] r_vs_pipe;
  logic [SYNC_DELAY-1:0] r_de_pipe;

  // Runs on every clk so the latency is in clocks, matching a downstream
  // pixel pipeline that is not itself gated by pix_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hs_pipe <= {SYNC_DELAY{~HSYNC_ACTIVE}};
      r_vs_pipe <= {SYNC_DELAY{~VSYNC_ACTIVE}};
      r_de_pipe <= '0;
    end else begin
      r_hs_pipe[0] <= r_hsync;
      r_vs_pipe[0] <= r_vsync;
      r_de_pipe[0] <= w_display_on;
      for (int i = 1; i < int'(SYNC_DELAY); i++) begin
        r_hs_pipe[i] <= r_hs_pipe[i-1];
        r_vs_pipe[i] <= r_vs_pipe[i-1];
        r_de_pipe[i] <= r_de_pipe[i-1];
      end
    end
  end

  assign hsync      = r_hs_pipe[SYNC_DELAY-1];
  assign vsync      = r_vs_pipe[SYNC_DELAY-1];
  assign display_on = r_de_pipe[SYNC_DELAY-1];
`else
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign display_on = w_display_on;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance and a tiny
// 16x12 instance (FC_W=4, FRAME_INIT=15, active-low hsync) share clk, reset
// and pix_en so frame-level behaviour can be covered in a few hundred clocks.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_SYNC_DELAY_EN
  localparam int Dly = 2;
`else
  localparam int Dly = 0;
`endif

  logic clk;
  logic reset;
  logic pix_en;

  logic [9:0]  hpos, vpos;
  logic        hsync, vsync, display_on, line_start, frame_start, in_vblank;
  logic [11:0] frame_count;

  logic [4:0]  hpos2, vpos2;
  logic        hsync2, vsync2, display_on2, line_start2, frame_start2, in_vblank2;
  logic [3:0]  frame_count2;

  int n_tests = 0;
  int n_fail  = 0;

  vga_timing_gen dut (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .hpos        (hpos),
    .vpos        (vpos),
    .hsync       (hsync),
    .vsync       (vsync),
    .display_on  (display_on),
    .line_start  (line_start),
    .frame_start (frame_start),
    .in_vblank   (in_vblank),
    .frame_count (frame_count)
  );

  vga_timing_gen #(
    .H_DISPLAY    (8),
    .H_FRONT      (2),
    .H_SYNC       (3),
    .H_BACK       (3),
    .V_DISPLAY    (6),
    .V_BOTTOM     (2),
    .V_SYNC       (2),
    .V_TOP        (2),
    .HSYNC_ACTIVE (1'b0),
    .VSYNC_ACTIVE (1'b1),
    .CW           (5),
    .FC_W         (4),
    .FRAME_INIT   (15)
  ) dut_small (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .hpos        (hpos2),
    .vpos        (vpos2),
    .hsync       (hsync2),
    .vsync       (vsync2),
    .display_on  (display_on2),
    .line_start  (line_start2),
    .frame_start (frame_start2),
    .in_vblank   (in_vblank2),
    .frame_count (frame_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Line-0 aggregates (default instance) and frame-0 aggregates (small one).
  int hs_cnt, hs_first, hs_last;
  int de_cnt, de_first, de_last;
  int vs_any, vb_any;
  int vs2_cnt, vs2_first, vs2_last;
  int vb2_cnt, vb2_first;
  int hs2_low, de2_cnt;

  initial begin
    reset  = 1'b1;
    pix_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_hpos", hpos, 0);
    check_eq("rst_vpos", vpos, 0);
    check_eq("rst_hsync", hsync, 0);
    check_eq("rst_vsync", vsync, 0);
    check_eq("rst_fc", frame_count, 0);
    check_eq("rst_line_start", line_start, 1);
    check_eq("rst_frame_start", frame_start, 1);
    check_eq("rst_small_hsync", hsync2, 1);
    check_eq("rst_small_fc", frame_count2, 15);

    // Run to hpos=123, then assert reset mid-line.
    reset = 1'b0;
    repeat (123) @(negedge clk);
    #1;
    check_eq("pre_rst_hpos", hpos, 123);
    reset = 1'b1;
    #1;
    check_eq("async_rst_hpos", hpos, 0);
    @(negedge clk);
    reset = 1'b0;

    hs_cnt = 0; hs_first = -1; hs_last = -1;
    de_cnt = 0; de_first = -1; de_last = -1;
    vs_any = 0; vb_any = 0;
    vs2_cnt = 0; vs2_first = -1; vs2_last = -1;
    vb2_cnt = 0; vb2_first = -1;
    hs2_low = 0; de2_cnt = 0;

    // c counts pix_en edges since reset release.
    for (int c = 0; c <= 1600; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c < 800) begin
        if (hsync) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = c;
          hs_last = c;
        end
        if (display_on) begin
          de_cnt++;
          if (de_first < 0) de_first = c;
          de_last = c;
        end
      end
      if (vsync) vs_any++;
      if (in_vblank) vb_any++;
      if (c < 192) begin
        if (vsync2) begin
          vs2_cnt++;
          if (vs2_first < 0) vs2_first = c;
          vs2_last = c;
        end
        if (in_vblank2) begin
          vb2_cnt++;
          if (vb2_first < 0) vb2_first = c;
        end
        if (!hsync2) hs2_low++;
        if (display_on2) de2_cnt++;
      end
      case (c)
        0:   check_eq("rel_hpos0", hpos, 0);
        1:   check_eq("rel_hpos1", hpos, 1);
        2:   check_eq("rel_hpos2", hpos, 2);
        799: begin
          check_eq("eol_hpos", hpos, 799);
          check_eq("eol_vpos", vpos, 0);
          check_eq("eol_line_start", line_start, 0);
        end
        800: begin
          check_eq("wrap_hpos", hpos, 0);
          check_eq("wrap_vpos", vpos, 1);
          check_eq("wrap_line_start", line_start, 1);
          check_eq("wrap_frame_start", frame_start, 0);
          check_eq("wrap_fc", frame_count, 0);
        end
        801: check_eq("post_wrap_line_start", line_start, 0);
        191: begin
          check_eq("small_last_hpos", hpos2, 15);
          check_eq("small_last_vpos", vpos2, 11);
          check_eq("small_last_fc", frame_count2, 15);
          check_eq("small_last_fs", frame_start2, 0);
        end
        192: begin
          check_eq("small_fwrap_hpos", hpos2, 0);
          check_eq("small_fwrap_vpos", vpos2, 0);
          check_eq("small_fwrap_fs", frame_start2, 1);
          check_eq("small_fwrap_fc", frame_count2, 0);
        end
        193: check_eq("small_fs_pulse", frame_start2, 0);
        384: check_eq("small_fc_2nd", frame_count2, 1);
        default: ;
      endcase
    end

    check_eq("hs_cnt", hs_cnt, 96);
    check_eq("hs_first", hs_first, 656 + Dly);
    check_eq("hs_last", hs_last, 751 + Dly);
    check_eq("de_cnt", de_cnt, 640);
    check_eq("de_first", de_first, Dly);
    check_eq("de_last", de_last, 639 + Dly);
    check_eq("vs_never", vs_any, 0);
    check_eq("vblank_never", vb_any, 0);
    check_eq("fc_hold", frame_count, 0);
    check_eq("small_vs_cnt", vs2_cnt, 32);
    check_eq("small_vs_first", vs2_first, 128 + Dly);
    check_eq("small_vs_last", vs2_last, 159 + Dly);
    check_eq("small_vb_cnt", vb2_cnt, 96);
    check_eq("small_vb_first", vb2_first, 96);
    check_eq("small_hs_low", hs2_low, 36);
    check_eq("small_de_cnt", de2_cnt, 48);

    // Clock-enable toggling at the start of line 2 (small instance at 0,4).
    check_eq("en_ls_on", line_start, 1);
    pix_en = 1'b0;
    #1;
    check_eq("en_ls_off", line_start, 0);
    check_eq("en_small_ls_off", line_start2, 0);
    @(negedge clk);
    #1;
    check_eq("en_hold0", hpos, 0);
    check_eq("en_hold_ls", line_start, 0);
    pix_en = 1'b1;
    @(negedge clk);
    #1;
    check_eq("en_adv1", hpos, 1);
    pix_en = 1'b0;
    @(negedge clk);
    #1;
    check_eq("en_hold1", hpos, 1);
    pix_en = 1'b1;
    @(negedge clk);
    #1;
    check_eq("en_adv2", hpos, 2);
    check_eq("en_vpos", vpos, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 sync generator.
- Produces hsync, vsync, display_on and the hpos/vpos beam coordinates.
- Timing, sync polarity and counter widths are set by parameters.
- Adds a pixel clock-enable, line/frame start strobes, a vblank flag and a free-running frame counter. Pattern generators in the VGA demos use these directly, so they no longer keep their own vsync-driven counters.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_BOTTOM, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_TOP, 33, vertical back porch (lines)
- HSYNC_ACTIVE, 1, level of hsync during the sync pulse (1 = active-high, TinyVGA wiring)
- VSYNC_ACTIVE, 1, level of vsync during the sync pulse
- CW, 10, width of hpos/vpos; must hold H_TOTAL-1 and V_TOTAL-1
- FC_W, 12, frame counter width
- FRAME_INIT, 0, frame_count value loaded on reset
- SYNC_DELAY, 2, pipeline stages used only by the optional feature (1..8)

Ports:
- clk  input  1  pixel/system clock
- reset  input  1  asynchronous, active-high reset
- pix_en  input  1  clock enable; counters advance only on clk edges where pix_en=1
- hpos  output  CW  horizontal position, 0..H_TOTAL-1
- vpos  output  CW  vertical position, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, polarity per HSYNC_ACTIVE
- vsync  output  1  vertical sync, polarity per VSYNC_ACTIVE
- display_on  output  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY
- line_start  output  1  high while hpos==0 and pix_en=1
- frame_start  output  1  high while hpos==0, vpos==0 and pix_en=1
- in_vblank  output  1  high when vpos>=V_DISPLAY
- frame_count  output  FC_W  completed-frame counter

Behaviour:
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800 at defaults)
  - V_TOTAL = V_DISPLAY+V_BOTTOM+V_SYNC+V_TOP (525 at defaults)
  - H_SS = H_DISPLAY+H_FRONT; H_SE = H_SS+H_SYNC-1
  - V_SS = V_DISPLAY+V_BOTTOM; V_SE = V_SS+V_SYNC-1
- Reset (asynchronous assert, released on clk):
  - hpos=0, vpos=0, frame_count=FRAME_INIT
  - hsync=~HSYNC_ACTIVE, vsync=~VSYNC_ACTIVE
  - Strobes follow their decode from the reset counter values.
  - Reset mid-frame restarts at (0,0) immediately. No partial line is completed.
- Counter advance, on clk with pix_en=1:
  - If hpos==H_TOTAL-1: hpos<=0, and vpos wraps to 0 if vpos==V_TOTAL-1, else vpos<=vpos+1.
  - Otherwise hpos<=hpos+1.
  - pix_en=0: all registers hold. line_start and frame_start are 0 that cycle.
- Frame count:
  - frame_count<=frame_count+1 on the same edge that wraps (H_TOTAL-1,V_TOTAL-1) to (0,0).
  - Wraps modulo 2^FC_W.
- Output decode:
  - hsync = HSYNC_ACTIVE when H_SS<=hpos<=H_SE, else ~HSYNC_ACTIVE.
  - vsync is decoded the same way from vpos against V_SS..V_SE.
  - hsync and vsync are registered from the next-state counter values, so they are aligned with hpos/vpos (zero lag). This differs from the old generator, whose syncs lagged by one clock.
  - display_on, in_vblank and the strobes are combinational from the hpos/vpos registers.
- Widths:
  - All compares are unsigned at CW bits.
  - Parameter sets with H_TOTAL>2^CW or V_TOTAL>2^CW are illegal; a simulation-time $error is required.
- Boundaries:
  - Line wrap and frame wrap happen on the same edge at (H_TOTAL-1,V_TOTAL-1).
  - vsync spans whole lines, from hpos=0 of line V_SS to hpos=H_TOTAL-1 of line V_SE.

Optional Feature:
- Macro: VGA_TIMING_SYNC_DELAY_EN.
- Defined:
  - hsync, vsync and display_on are each passed through a SYNC_DELAY-deep shift register.
  - The shift registers advance on every clk, independent of pix_en. On reset they are filled with the inactive levels (display_on=0).
  - This aligns sync with a pattern pipeline of SYNC_DELAY latency.
  - hpos, vpos, the strobes, in_vblank and frame_count stay undelayed.
- Undefined: no delay stages; outputs as in Behaviour; the SYNC_DELAY parameter is ignored.

Test Plan:
1. Defaults, reset asserted mid-line at hpos=123, pix_en=1 → hpos/vpos=0 asynchronously, hsync=0, vsync=0, frame_count=0; after release hpos counts 0,1,2…
2. pix_en=1, step to hpos=799, vpos=0 → next edge hpos=0, vpos=1, line_start=1 for one cycle; frame_count unchanged.
3. Sweep one line → hsync=1 exactly for hpos 656..751 (96 cycles); display_on=1 for hpos 0..639 on vpos<480 only.
4. Run to (799,524) → next edge (0,0), frame_start=1, frame_count=1; vsync=1 for vpos 490..491; in_vblank=1 for vpos 480..524. With FC_W=4, FRAME_INIT=15 → frame_count wraps to 0.
5. pix_en toggling 1,0,1,0 → hpos advances every second clk; strobes never high on pix_en=0 cycles. Params HSYNC_ACTIVE=0 → hsync low only in 656..751.
6. VGA_TIMING_SYNC_DELAY_EN defined, SYNC_DELAY=2 → hsync rises 2 clk after hpos reaches 656; display_on falls 2 clk after hpos reaches 640; hpos itself is unchanged.
